// File: rtl/regfile_wb.sv
// regfile_wb: write-back stage and integer register file.
// Captures the X-stage destination, commits the M-stage result one cycle
// later, and serves two decode read ports with X/M bypassing plus a
// load-use stall.
// Optional feature macro: REGFILE_FWD_X_EN. When defined, a non-load result
// in X is forwarded straight to decode. When undefined, any X hit stalls
// decode for one cycle and the value is then taken from the M bypass.
module regfile_wb #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rd_addr_x,
  input  logic            rd_we_x,
  input  logic            rdx_v,
  input  logic            flush_x,
  input  logic [XLEN-1:0] rd_data_x,
  input  logic [XLEN-1:0] rd_data_m,
  input  logic [4:0]      rs1_addr_d,
  input  logic            rs1_ren_d,
  input  logic [4:0]      rs2_addr_d,
  input  logic            rs2_ren_d,
  output logic [XLEN-1:0] rs1_data_d,
  output logic [XLEN-1:0] rs2_data_d,
  output logic            load_stall,
  output logic [4:0]      rd_addr_w,
  output logic            rd_we_w
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [4:0]      rd_addr_m_q, rd_addr_m_d;
  logic            rd_we_m_q, rd_we_m_d;

  logic            commit;
  logic            x_live;
  logic            x_hit1, x_hit2;
  logic            m_hit1, m_hit2;
  logic            x_fwd;
  logic            x_stall;

`ifdef REGFILE_FWD_X_EN
  // A finished ALU result in X may be forwarded; only loads in X stall.
  assign x_fwd   = rdx_v;
  assign x_stall = ~rdx_v;
`else
  // No X-to-decode path: every X hit stalls and is later served from M.
  logic fwd_unused;
  assign fwd_unused = rdx_v;
  assign x_fwd      = 1'b0;
  assign x_stall    = 1'b1;
`endif

  assign x_live = rd_we_x & ~flush_x;
  assign commit = rd_we_m_q & (rd_addr_m_q != 5'd0);
  assign x_hit1 = x_live & (rd_addr_x == rs1_addr_d);
  assign x_hit2 = x_live & (rd_addr_x == rs2_addr_d);
  assign m_hit1 = rd_we_m_q & (rd_addr_m_q == rs1_addr_d);
  assign m_hit2 = rd_we_m_q & (rd_addr_m_q == rs2_addr_d);

  assign rd_addr_w = rd_addr_m_q;
  assign rd_we_w   = commit;

  // Priority mux for one read port: x0, then X, then M, then the array.
  function automatic logic [XLEN-1:0] read_port(
    input logic [4:0]      addr,
    input logic            use_x,
    input logic            use_m,
    input logic [XLEN-1:0] dx,
    input logic [XLEN-1:0] dm,
    input logic [XLEN-1:0] rf
  );
    logic [XLEN-1:0] val;
    if (addr == 5'd0) begin
      val = '0;
    end else if (use_x) begin
      val = dx;
    end else if (use_m) begin
      val = dm;
    end else begin
      val = rf;
    end
    return val;
  endfunction

  // Next-state for the X-to-M pipeline register; a flushed X never reaches M.
  always_comb begin
    rd_addr_m_d = rd_addr_x;
    rd_we_m_d   = rd_we_x & ~flush_x;
  end

  // Next-state for the register array; x0 is forced to zero.
  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      regs_d[rd_addr_m_q] = rd_data_m;
    end
    regs_d[0] = '0;
  end

  // State registers; reset discards any in-flight commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      rd_addr_m_q <= '0;
      rd_we_m_q   <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      rd_addr_m_q <= rd_addr_m_d;
      rd_we_m_q   <= rd_we_m_d;
    end
  end

  // Decode read data and load-use stall, held at zero while in reset.
  always_comb begin
    rs1_data_d = '0;
    rs2_data_d = '0;
    load_stall = 1'b0;
    if (!reset) begin
      rs1_data_d = read_port(rs1_addr_d, x_hit1 & x_fwd, m_hit1,
                             rd_data_x, rd_data_m, regs_q[rs1_addr_d]);
      rs2_data_d = read_port(rs2_addr_d, x_hit2 & x_fwd, m_hit2,
                             rd_data_x, rd_data_m, regs_q[rs2_addr_d]);
      load_stall = (rs1_ren_d & (rs1_addr_d != 5'd0) & x_hit1 & x_stall) |
                   (rs2_ren_d & (rs2_addr_d != 5'd0) & x_hit2 & x_stall);
    end
  end

endmodule
